// File: rtl/sipm_pkg.sv
// Shared definitions for the SiPM event collector: default sizes, channel FSM states
// and the event record layout.
package sipm_pkg;

    localparam int TIMESTAMP_LEN = 40;
    localparam int NUM_CH        = 4;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CLEARING = 2'd1,
        SETTLE   = 2'd2
    } ch_state_t;

    typedef struct packed {
        logic [$clog2(NUM_CH)-1:0] channel;
        logic [1:0]                height;
        logic [TIMESTAMP_LEN-1:0]  timestamp;
    } event_t;

endpackage

// File: rtl/sipm_event_fifo.sv
// Show-ahead event buffer: the head entry is visible whenever the buffer is non-empty.
module sipm_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && valid && !flush;
    // Empty buffer presents zeros so the data outputs follow reset without resetting the array.
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sipm_event_collector.sv
// Collects hits from several SiPM readers: round-robin grant into an event FIFO,
// then a timed clear pulse and settle period per granted channel.
module sipm_event_collector #(
    parameter int TIMESTAMP_LEN = sipm_pkg::TIMESTAMP_LEN,
    parameter int NUM_CH        = sipm_pkg::NUM_CH,
    parameter int FIFO_DEPTH    = 8,
    parameter int CLEAR_CYCLES  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [2*NUM_CH-1:0]             sipm_height,
    input  logic [TIMESTAMP_LEN*NUM_CH-1:0] sipm_timestamp,
    input  logic                            sw_clear,
    output logic [NUM_CH-1:0]               clear_latches,
    output logic                            event_valid,
    input  logic                            event_ready,
    output logic [$clog2(NUM_CH)-1:0]       event_channel,
    output logic [1:0]                      event_height,
    output logic [TIMESTAMP_LEN-1:0]        event_timestamp,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    import sipm_pkg::*;

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int REC_W = CH_W + 2 + TIMESTAMP_LEN;
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    logic [NUM_CH-1:0]        cand;
    logic [CH_W-1:0]          last_q;
    logic [CH_W-1:0]          grant_idx;
    logic [CH_W:0]            idx;
    logic                     grant;
    logic                     fifo_full;
    logic [1:0]               sel_height;
    logic [TIMESTAMP_LEN-1:0] sel_ts;
    logic [REC_W-1:0]         pop_rec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             clear_q;

        assign cand[g]          = (state_q == ARMED) && (sipm_height[2*g +: 2] != 2'b00);
        assign clear_latches[g] = clear_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (sw_clear) begin
                state_d = CLEARING;
                cnt_d   = CLR_LOAD;
            end else begin
                case (state_q)
                    ARMED: begin
                        if (grant && grant_idx == CH_W'(g)) begin
                            state_d = CLEARING;
                            cnt_d   = CLR_LOAD;
                        end
                    end
                    CLEARING: begin
                        if (cnt_q == '0) state_d = SETTLE;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                    SETTLE:  state_d = ARMED;
                    default: state_d = ARMED;
                endcase
            end
        end

        // Clear is registered from the next state so it rises on the grant edge itself.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= CLEARING;
                cnt_q   <= CLR_LOAD;
                clear_q <= 1'b1;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                clear_q <= (state_d == CLEARING);
            end
        end
    end

    // Scan downwards so the channel nearest after the last grant is the one that sticks.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = {1'b0, last_q} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
            if (cand[idx[CH_W-1:0]]) begin
                grant     = 1'b1;
                grant_idx = idx[CH_W-1:0];
            end
        end
        if (fifo_full || sw_clear) grant = 1'b0;
    end

    always_comb begin
        sel_height = 2'b00;
        sel_ts     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                sel_height = sipm_height[2*i +: 2];
                sel_ts     = sipm_timestamp[TIMESTAMP_LEN*i +: TIMESTAMP_LEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_q <= CH_W'(NUM_CH - 1);
        else if (grant) last_q <= grant_idx;
    end

    sipm_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (sw_clear),
        .push      (grant),
        .push_data ({grant_idx, sel_height, sel_ts}),
        .pop       (event_ready),
        .full      (fifo_full),
        .valid     (event_valid),
        .data      (pop_rec),
        .count     (fifo_count)
    );

    assign event_channel   = pop_rec[REC_W-1 -: CH_W];
    assign event_height    = pop_rec[TIMESTAMP_LEN +: 2];
    assign event_timestamp = pop_rec[TIMESTAMP_LEN-1:0];

endmodule

// File: tb/tb_sipm_event_collector.sv
// Bench for sipm_event_collector: directed table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_sipm_event_collector;
    localparam int TS    = 40;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam int CC    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2*NCH-1:0]  height = '0;
    logic [TS*NCH-1:0] tstamp = '0;
    logic              sw_clear = 1'b0;
    logic              ready = 1'b0;
    logic [NCH-1:0]    clr;
    logic              ev_valid;
    logic [1:0]        ev_ch;
    logic [1:0]        ev_h;
    logic [TS-1:0]     ev_ts;
    logic [3:0]        count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sipm_event_collector #(
        .TIMESTAMP_LEN (TS),
        .NUM_CH        (NCH),
        .FIFO_DEPTH    (DEPTH),
        .CLEAR_CYCLES  (CC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sipm_height     (height),
        .sipm_timestamp  (tstamp),
        .sw_clear        (sw_clear),
        .clear_latches   (clr),
        .event_valid     (ev_valid),
        .event_ready     (ready),
        .event_channel   (ev_ch),
        .event_height    (ev_h),
        .event_timestamp (ev_ts),
        .fifo_count      (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: each channel is blocked for a number of edges after a grant,
    // events live in a plain queue.
    typedef struct {
        int           ch;
        int           h;
        logic [TS-1:0] ts;
    } rec_t;

    rec_t q[$];
    int   blk[NCH];
    int   rr;

    task automatic model_reset();
        q.delete();
        foreach (blk[i]) blk[i] = CC + 1;
        rr = NCH - 1;
    endtask

    task automatic model_edge();
        int g;
        g = -1;
        if (sw_clear) begin
            q.delete();
            foreach (blk[i]) blk[i] = CC + 1;
            return;
        end
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (rr + k) % NCH;
            if (g < 0 && blk[c] == 0 && height[2*c +: 2] != 2'b00) g = c;
        end
        if (q.size() == DEPTH) g = -1;
        if (q.size() > 0 && ready) void'(q.pop_front());
        foreach (blk[i]) begin
            if (i == g)          blk[i] = CC + 1;
            else if (blk[i] > 0) blk[i]--;
        end
        if (g >= 0) begin
            rec_t r;
            r.ch = g;
            r.h  = int'(height[2*g +: 2]);
            r.ts = tstamp[TS*g +: TS];
            q.push_back(r);
            rr = g;
        end
    endtask

    task automatic model_check();
        logic [NCH-1:0] eclr;
        string tag;
        tag = $sformatf("cyc%0d", cyc);
        foreach (blk[i]) eclr[i] = (blk[i] > 1);
        check({tag, " model valid"}, 64'(ev_valid), 64'(q.size() > 0));
        check({tag, " model count"}, 64'(count), 64'(q.size()));
        check({tag, " model clear"}, 64'(clr), 64'(eclr));
        if (q.size() > 0) begin
            check({tag, " model ch"}, 64'(ev_ch), 64'(q[0].ch));
            check({tag, " model h"},  64'(ev_h),  64'(q[0].h));
            check({tag, " model ts"}, 64'(ev_ts), 64'(q[0].ts));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        model_check();
    endtask

    // Assert reset away from any clock edge and confirm outputs drop immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("reset valid", 64'(ev_valid), 64'(0));
        check("reset count", 64'(count), 64'(0));
        check("reset clear", 64'(clr), 64'hF);
        check("reset ch",    64'(ev_ch), 64'(0));
        check("reset h",     64'(ev_h), 64'(0));
        check("reset ts",    64'(ev_ts), 64'(0));
        height   = '0;
        ready    = 1'b0;
        sw_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] hgt;
        logic       rdy;
        logic       valid;
        int         cnt;
        logic [3:0] clr;
        int         ch;
        int         h;
    } vec_t;

    vec_t          tab[15];
    logic [TS-1:0] ts_tab[NCH];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [63:0] rv;

        ts_tab[0] = 40'h00_0000_00AA;
        ts_tab[1] = 40'h00_0000_00BB;
        ts_tab[2] = 40'h00_0000_0100;
        ts_tab[3] = '1;
        tstamp = {ts_tab[3], ts_tab[2], ts_tab[1], ts_tab[0]};

        // Three settle edges, three simultaneous hits (0,1,3), drain, then a single hit on ch2.
        tab[0]  = '{8'h00, 1'b0, 1'b0, 0, 4'hF, 0, 0};
        tab[1]  = '{8'h00, 1'b0, 1'b0, 0, 4'h0, 0, 0};
        tab[2]  = '{8'h00, 1'b0, 1'b0, 0, 4'h0, 0, 0};
        tab[3]  = '{8'hC9, 1'b0, 1'b1, 1, 4'h1, 0, 1};
        tab[4]  = '{8'hC9, 1'b0, 1'b1, 2, 4'h3, 0, 1};
        tab[5]  = '{8'hC9, 1'b0, 1'b1, 3, 4'hA, 0, 1};
        tab[6]  = '{8'h00, 1'b0, 1'b1, 3, 4'h8, 0, 1};
        tab[7]  = '{8'h00, 1'b1, 1'b1, 2, 4'h0, 1, 2};
        tab[8]  = '{8'h00, 1'b1, 1'b1, 1, 4'h0, 3, 3};
        tab[9]  = '{8'h00, 1'b1, 1'b0, 0, 4'h0, 0, 0};
        tab[10] = '{8'h20, 1'b0, 1'b1, 1, 4'h4, 2, 2};
        tab[11] = '{8'h20, 1'b0, 1'b1, 1, 4'h4, 2, 2};
        tab[12] = '{8'h20, 1'b0, 1'b1, 1, 4'h0, 2, 2};
        tab[13] = '{8'h00, 1'b0, 1'b1, 1, 4'h0, 2, 2};
        tab[14] = '{8'h00, 1'b1, 1'b0, 0, 4'h0, 0, 0};

        rst_n = 1'b1;
        #1;
        do_reset();

        for (int r = 0; r < 15; r++) begin
            height = tab[r].hgt;
            ready  = tab[r].rdy;
            step();
            check($sformatf("tab%0d valid", r), 64'(ev_valid), 64'(tab[r].valid));
            check($sformatf("tab%0d count", r), 64'(count), 64'(tab[r].cnt));
            check($sformatf("tab%0d clear", r), 64'(clr), 64'(tab[r].clr));
            if (tab[r].valid) begin
                check($sformatf("tab%0d ch", r), 64'(ev_ch), 64'(tab[r].ch));
                check($sformatf("tab%0d h", r),  64'(ev_h), 64'(tab[r].h));
                check($sformatf("tab%0d ts", r), 64'(ev_ts), 64'(ts_tab[tab[r].ch]));
            end
        end

        // FIFO fills to 8 with every channel hitting; the next candidate must wait uncleared.
        do_reset();
        repeat (3) step();
        height = 8'h55;
        repeat (8) step();
        check("full count", 64'(count), 64'(8));
        repeat (2) step();
        check("full held count", 64'(count), 64'(8));
        check("full ch0 uncleared", 64'(clr[0]), 64'(0));
        ready = 1'b1;
        step();
        check("full pop no push", 64'(count), 64'(7));
        check("full pop head", 64'(ev_ch), 64'(1));
        ready = 1'b0;
        step();
        check("refill count", 64'(count), 64'(8));
        check("refill ch0 cleared", 64'(clr[0]), 64'(1));

        // Software clear with five events buffered, overriding a simultaneous pop.
        height = '0;
        ready  = 1'b1;
        repeat (3) step();
        check("pre-clear count", 64'(count), 64'(5));
        sw_clear = 1'b1;
        step();
        check("swclr count", 64'(count), 64'(0));
        check("swclr valid", 64'(ev_valid), 64'(0));
        check("swclr clear1", 64'(clr), 64'hF);
        sw_clear = 1'b0;
        ready    = 1'b0;
        step();
        check("swclr clear2", 64'(clr), 64'hF);
        step();
        check("swclr clear3", 64'(clr), 64'h0);

        // Asynchronous reset while an event is presented.
        height = 8'h08;
        repeat (3) step();
        check("prereset valid", 64'(ev_valid), 64'(1));
        do_reset();

        // Random traffic: first a mostly-stalled consumer, then a mostly-ready one.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0) height[2*c +: 2] = 2'($urandom_range(1, 3));
                else                           height[2*c +: 2] = 2'b00;
                rv = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) tstamp[TS*c +: TS] = '1;
                else                           tstamp[TS*c +: TS] = rv[TS-1:0];
            end
            ready    = ($urandom_range(0, 99) < ((n < 300) ? 20 : 70));
            sw_clear = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipm_event_collector.md
SIPM_EVENT_COLLECTOR -- requirements
Module: sipm_event_collector

Interface
REQ-001 Parameter TIMESTAMP_LEN, default 40: timestamp width, matches the per-SiPM readers.
REQ-002 Parameter NUM_CH, default 4: number of SiPM reader channels served.
REQ-003 Parameter FIFO_DEPTH, default 8: event buffer depth, power of two.
REQ-004 Parameter CLEAR_CYCLES, default 2: width of each per-channel clear pulse, in clocks, 1..15.
REQ-005 clk  in  1: single clock, rising edge.
REQ-006 rst_n  in  1: asynchronous, active-low reset.
REQ-007 sipm_height  in  2*NUM_CH: per-channel signal height from each reader; channel i is bits [2i+1:2i]; 0 means no hit.
REQ-008 sipm_timestamp  in  TIMESTAMP_LEN*NUM_CH: per-channel latched timestamp from each reader.
REQ-009 sw_clear  in  1: synchronous request to clear all channels and flush the FIFO.
REQ-010 clear_latches  out  NUM_CH: registered per-channel clear to each reader, active high.
REQ-011 event_valid  out  1: an event is presented.
REQ-012 event_ready  in  1: consumer accepts the event.
REQ-013 event_channel  out  clog2(NUM_CH): channel index of the presented event.
REQ-014 event_height  out  2: height of the presented event, 1..3.
REQ-015 event_timestamp  out  TIMESTAMP_LEN: timestamp of the presented event.
REQ-016 fifo_count  out  clog2(FIFO_DEPTH)+1: number of buffered events.

Function
REQ-017 Each channel has its own FSM with states ARMED, CLEARING and SETTLE.
REQ-018 A channel is a candidate when it is ARMED and its height is nonzero at a clock edge.
REQ-019 Per cycle, at most one candidate is granted, and only when the FIFO is not full.
REQ-020 Grants are round-robin: search starts at the channel after the last granted channel; after reset the search starts at channel 0.
REQ-021 On a grant, {channel, height, timestamp} is pushed at that edge, and the channel enters CLEARING with clear_latches[i]=1 from that edge for exactly CLEAR_CYCLES cycles.
REQ-022 After CLEARING, the channel holds SETTLE for 1 cycle with clear low, then returns to ARMED, so a reader's stale output is never pushed twice.
REQ-023 A candidate that is not granted, whether because the FIFO is full or it lost arbitration, stays ARMED and is neither cleared nor dropped; the reader holds its data.
REQ-024 The FIFO is show-ahead: an event pushed at edge N gives event_valid=1 after edge N when the FIFO was empty.
REQ-025 A pop occurs at an edge where event_valid and event_ready are both 1; the outputs hold stable while valid is high and ready is low.
REQ-026 Simultaneous push and pop are allowed when not full; fifo_count then stays unchanged.
REQ-027 A push is refused when full, even if a pop occurs in the same cycle.
REQ-028 Read and write pointers wrap modulo FIFO_DEPTH; fifo_count saturates at FIFO_DEPTH and never underflows.
REQ-029 sw_clear=1 at an edge flushes the FIFO, with count 0 and valid 0 after that edge.
REQ-030 sw_clear=1 forces every channel into CLEARING for CLEAR_CYCLES cycles and blocks grants that cycle; it overrides any simultaneous grant or pop.
REQ-031 A timestamp value of all ones is passed through unchanged; only height decides a hit.

Reset
REQ-032 rst_n low asynchronously sets clear_latches to all ones, event_valid to 0, fifo_count to 0, all channels to CLEARING with full count, and the round-robin pointer to channel NUM_CH-1.
REQ-033 After rst_n is released, the channels complete CLEARING and SETTLE before the first grant.
REQ-034 The event data outputs reset to 0.
REQ-035 Reset mid-operation discards all buffered events.

Structure
REQ-036 Shared package sipm_pkg holds TIMESTAMP_LEN, NUM_CH, the channel FSM state enum, and the event record type {channel, height, timestamp}.
REQ-037 The FIFO is one sub-module, sipm_event_fifo, parameterised by depth and record width; the arbiter and channel FSMs stay in the top.

Verification
REQ-038 Test 1: channel 2 height=2, ts=0x100 at edge 10 -> push at edge 10; clear_latches[2] high for edges 10-11; event ch=2, h=2, ts=0x100 valid after edge 10; fifo_count=1.
REQ-039 Test 2: channels 0, 1 and 3 hit at the same edge -> events in order 0, 1, 3 on consecutive edges; each clear is offset by one cycle.
REQ-040 Test 3: event_ready=0 with 9 hits on alternating channels -> count reaches 8; the 9th channel stays uncleared; one pop lets it be pushed the next cycle.
REQ-041 Test 4: height held nonzero through CLEARING and SETTLE -> exactly one event is pushed.
REQ-042 Test 5: sw_clear with count=5 -> count 0, valid 0, all clear_latches high for 2 cycles.
REQ-043 Test 6: rst_n asserted mid-transfer -> outputs are at reset values immediately, without waiting for a clock edge.
